inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of inst_decoder.
- Keeps the program counter, issues word-aligned requests to instruction memory, and buffers returned words in a small in-order FIFO.
- Presents {instruction, PC} to the decoder with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered words and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, fetch buffer entries; power of two, ≥2.
- MAX_OUT, 4, maximum memory requests in flight (live + stale).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  returned instruction word.
- instruction  output  32  instruction to decoder (FIFO head).
- inst_pc  output  32  PC of the instruction.
- inst_valid  output  1  instruction/inst_pc valid.
- inst_ready  input  1  decoder accepts.
- redirect_valid  input  1  control-flow redirect, one-cycle pulse.
- redirect_pc  input  32  redirect target.
- misaligned  output  1  registered pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync deassert use):
  - fetch_pc = RESET_PC; FIFO empty; live_cnt = 0; drop_cnt = 0.
  - imem_req_valid = 0, inst_valid = 0, misaligned = 0.
  - instruction and inst_pc = 0.
- Request issue:
  - imem_req_valid = !redirect_valid && (fifo_cnt + live_cnt < DEPTH) && (live_cnt + drop_cnt < MAX_OUT).
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps at 2^32 to 0); live_cnt++.
  - Requests are combinational from state only; no dependence on imem_rsp_valid in the same cycle.
- Response accept, on imem_rsp_valid:
  - If drop_cnt > 0: word discarded, drop_cnt--.
  - Else: word pushed to FIFO tail with its PC; live_cnt--.
  - The PC of each pushed word is tracked by resp_pc, which starts at the redirect/reset PC and increments by 4 per accepted live response.
  - The FIFO never overflows, by construction of the issue rule. A live response with fifo full is an assertion failure.
- Output:
  - inst_valid = FIFO not empty; instruction/inst_pc = head entry.
  - Pop on inst_valid && inst_ready.
  - Minimum latency is request accepted at cycle N, response at N+1, inst_valid at N+2.
  - Head is stable while inst_valid && !inst_ready.
- Redirect (redirect_valid = 1 in cycle N):
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}; FIFO cleared.
  - drop_cnt <= drop_cnt + live_cnt, minus 1 if a response arrives in cycle N (that response is discarded); live_cnt <= 0.
  - No request issued in cycle N; first new request in N+1.
  - misaligned <= (redirect_pc[1:0] != 0) for one cycle N+1; otherwise 0.
  - A pop in the same cycle N completes normally (that instruction counts as delivered); all other buffered entries are lost.
  - Back-to-back redirects: the latest one wins, and stale counts accumulate.
- Simultaneous push and pop on a full FIFO is legal (count unchanged).
- Reset asserted mid-operation: all state returns to reset values immediately. Responses still in flight after reset deassertion are the memory's responsibility; the memory is reset together with this block.
- Counter widths: live_cnt and drop_cnt are clog2(MAX_OUT+1) bits; fifo_cnt is clog2(DEPTH+1) bits.

Test Plan:
1. Reset, then release with RESET_PC = 0 and memory ready every cycle with 1-cycle latency → requests to 0x0, 0x4, 0x8…; inst_valid first high 2 cycles after the first accept; inst_pc = 0x0 with the word at 0x0.
2. Decoder stalls (inst_ready = 0) for 10 cycles → exactly 4 entries buffered; imem_req_valid drops once fifo_cnt + live_cnt = 4; head stays 0x0. On release, words are delivered in order 0x0…0xC with no loss or duplication.
3. Memory latency 3 cycles, with redirect to 0x100 while 3 requests are outstanding → the 3 stale responses are discarded; the next delivered instruction has inst_pc = 0x100 and the word from 0x100.
4. Redirect in the same cycle as a pop of 0x8 → 0x8 is consumed; the following delivered inst_pc = redirect target, and nothing from 0xC onward appears.
5. Redirect to 0x202 → misaligned pulses for one cycle; fetch resumes at 0x200.
6. Fetch near the top of the address space (RESET_PC = 0xFFFF_FFF8) → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc wraps identically.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding inst_decoder.
// Holds the fetch PC, issues word-aligned requests to instruction memory,
// and buffers returned words with their PCs in a small in-order FIFO.
// A redirect restarts fetch at the new target. Responses that are still
// in flight when the redirect happens are counted in drop_cnt and are
// discarded when they return, so only words for the new path reach the FIFO.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    // instruction memory response channel (in order, >=1 cycle latency)
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    // decoder side
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    // control-flow redirect
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    fetch_entry_t  fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;

    // live_cnt: accepted requests whose words will be kept.
    // drop_cnt: accepted requests issued before a redirect; their words
    //           are thrown away as they come back.
    logic [OW-1:0] live_cnt;
    logic [OW-1:0] drop_cnt;

    logic [31:0]   fetch_pc;   // next address to request
    logic [31:0]   resp_pc;    // PC of the next live word to be pushed

    logic [31:0]   room_sum;
    logic [31:0]   credit_sum;
    logic          room_ok;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_stale;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_base;

    // The FIFO must be able to hold every word that is still coming back
    // for the current path, and the memory may have at most MAX_OUT
    // responses pending in total (live and stale alike).
    assign room_sum   = 32'(fifo_cnt) + 32'(live_cnt);
    assign credit_sum = 32'(live_cnt) + 32'(drop_cnt);
    assign room_ok    = room_sum < DEPTH;
    assign credit_ok  = credit_sum < MAX_OUT;

    // Request issue depends only on state and the redirect input. rst_n
    // gates the valid so that it is low for as long as reset is held.
    assign imem_req_valid = rst_n && !redirect_valid && room_ok && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is stale while any pre-redirect responses remain, because
    // memory returns them in order ahead of the new path's words.
    assign rsp_stale = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live  = imem_rsp_valid && (drop_cnt == '0);

    // A live word arriving together with a redirect belongs to the old path.
    assign push = rsp_live && !redirect_valid;

    assign inst_valid  = (fifo_cnt != '0);
    assign instruction = fifo_mem[rd_ptr].inst;
    assign inst_pc     = fifo_mem[rd_ptr].pc;
    assign pop         = inst_valid && inst_ready;

    assign redirect_base = {redirect_pc[31:2], 2'b00};

    // PCs, in-flight counters and FIFO pointers; a redirect overrides all
    // normal updates but still lets a same-cycle pop complete downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            live_cnt <= '0;
            // every outstanding request becomes stale, less the one whose
            // response is being swallowed right now
            drop_cnt <= drop_cnt + live_cnt - OW'(imem_rsp_valid);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rsp_stale) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
            live_cnt <= live_cnt + OW'(req_fire) - OW'(rsp_live);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; cleared on reset so the decoder-facing outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= '{inst: imem_rsp_data, pc: resp_pc};
        end
    end

    // One-cycle flag for a redirect target that is not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // The issue rule keeps fifo_cnt + live_cnt <= DEPTH, so a live word
    // never finds the FIFO full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_cnt != CW'(DEPTH)));

    // Memory must not return more words than were requested.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (credit_sum != 32'd0));

    // Outstanding requests never exceed the memory's budget.
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_sum <= MAX_OUT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed + randomized bench for inst_fetch. A queue-based memory model
// returns words in order after a configurable latency; the reference model
// is the program-order rule: after reset or a redirect to T, requests go to
// T, T+4, ... and the decoder sees exactly T, T+4, ... with each word.
module tb_inst_fetch;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misaligned;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instruction   (instruction),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc, exp_req;
    int          issued, popped;
    bit          pop_seen;
    logic [31:0] pop_pc;
    bit          hold;
    logic [31:0] hold_pc, hold_inst;
    int          first_fire, first_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check before the rising edge,
    // advance the model at the edge, check registered outputs at next negedge.
    task automatic tick(input bit dec_rdy, input bit mem_rdy, input bit redir,
                        input logic [31:0] rpc);
        bit fire, pop, rsp;
        int due;
        inst_ready     = dec_rdy;
        imem_req_ready = mem_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'h0;
        #1;
        if (hold) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_pc", inst_pc, hold_pc);
            chk("hold_inst", instruction, hold_inst);
        end
        if (redir) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        if ((issued - popped >= DEPTH) || (mq.size() >= MAX_OUT))
            chk("req_throttle", 32'(imem_req_valid), 32'd0);
        fire = imem_req_valid && imem_req_ready;
        pop  = inst_valid && inst_ready;
        if (fire) chk("req_addr", imem_req_addr, exp_req);
        if (pop) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("instruction", instruction, mem_word(exp_pc));
            pop_seen = 1'b1;
            pop_pc   = inst_pc;
        end
        if (fire && first_fire < 0) first_fire = cyc;
        if (inst_valid && first_valid < 0) first_valid = cyc;
        hold      = inst_valid && !inst_ready && !redir;
        hold_pc   = inst_pc;
        hold_inst = instruction;
        @(posedge clk);
        if (rsp) void'(mq.pop_front());
        if (fire) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: imem_req_addr, due: due});
            last_due = due;
            exp_req  = exp_req + 32'd4;
            issued++;
        end
        if (pop) begin
            exp_pc = exp_pc + 32'd4;
            popped++;
        end
        if (redir) begin
            exp_pc  = {rpc[31:2], 2'b00};
            exp_req = exp_pc;
            issued  = 0;
            popped  = 0;
        end
        cyc++;
        @(negedge clk);
        chk("misaligned", 32'(misaligned), 32'(redir && (rpc[1:0] != 2'b00)));
    endtask

    // Asynchronous reset of DUT and memory model; released at a negedge.
    task automatic do_reset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        mq.delete();
        last_due    = 0;
        hold        = 1'b0;
        exp_pc      = RST_PC;
        exp_req     = RST_PC;
        issued      = 0;
        popped      = 0;
        first_fire  = -1;
        first_valid = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp);
        int n = 0;
        pop_seen = 1'b0;
        while (!pop_seen && n < 40) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk({tag, "_seen"}, 32'(pop_seen), 32'd1);
        if (pop_seen) chk(tag, pop_pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel, n, p0;
        #2;
        // 1: reset and streaming with 1-cycle memory
        do_reset();
        rel = cyc;
        lat = 1;
        repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t1_first_req_cycle", 32'(first_fire - rel), 32'd0);
        chk("t1_first_valid_latency", 32'(first_valid - first_fire), 32'd2);

        // 2: decoder stall fills the buffer and throttles requests
        repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t2_valid", 32'(inst_valid), 32'd1);
        chk("t2_req_stopped", 32'(imem_req_valid), 32'd0);
        chk("t2_buffered", 32'(issued - popped), 32'(DEPTH));
        chk("t2_head", inst_pc, exp_pc);
        p0 = popped;
        repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_drained", 32'(popped - p0 >= DEPTH), 32'd1);

        // 3: redirect with three requests outstanding on slow memory
        lat = 3;
        n = 0;
        while (mq.size() < 3 && n < 20) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("t3_outstanding", 32'(mq.size() >= 3), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        wait_pop("t3_first_pc", 32'h0000_0100);

        // 4: redirect in the same cycle as the pop of 0x8
        lat = 1;
        tick(1'b0, 1'b1, 1'b1, 32'h0);
        n = 0;
        while (!(inst_valid && inst_pc == 32'h8) && n < 30) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("t4_head_is_8", inst_pc, 32'h8);
        pop_seen = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        chk("t4_pop_with_redirect", pop_pc, 32'h8);
        wait_pop("t4_after_redirect", 32'h0000_0300);

        // 5: misaligned redirect
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0202);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        wait_pop("t5_aligned_pc", 32'h0000_0200);

        // 6: wrap at the top of the address space
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        wait_pop("t6_pc0", 32'hFFFF_FFF8);
        wait_pop("t6_pc1", 32'hFFFF_FFFC);
        wait_pop("t6_pc2", 32'h0000_0000);

        // reset in the middle of traffic
        lat = 2;
        repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0);
        do_reset();
        wait_pop("rst_restart_pc", RST_PC);

        // randomized traffic, latency, stalls and redirects
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
